audio_frame_streamer: RTL
=========================

// Module: audio_frame_streamer
// PURPOSE
//  Parametrised ping-pong framer between Audio_Controller sample output and the FFT sink. Selects/mixes channel,
//  applies saturating gain, packs FRAME_LEN samples per bank, streams complete frames out on a valid/ready/sop/eop
//  interface. Replaces dual-clock FIFO framing: runs in CLOCK_50 domain, never stalls audio input, counts drops.
// PARAMETERS
//  DATA_W     32    sample width, two's complement
//  FRAME_LEN  8192  samples per frame; power of two, >=4
//  ADDR_W     $clog2(FRAME_LEN)  bank address width (derived; not overridden)
// PORTS
//  CLOCK_50     in   1       system clock; all logic on posedge
//  reset        in   1       synchronous, active-high
//  flush        in   1       sync abort: empty both banks, zero pointers, FSM->IDLE
//  ch_sel       in   2       0=left 1=right 2=(L+R)>>>1 3=left
//  gain_shift   in   3       left shift 0..7, saturating
//  in_valid     in   1       one-cycle pulse per stereo sample (audio_in_available)
//  in_left      in   DATA_W  left sample
//  in_right     in   DATA_W  right sample
//  src_ready    in   1       downstream ready
//  src_valid    out  1       src_data valid
//  src_sop      out  1       first sample of frame
//  src_eop      out  1       last sample of frame
//  src_data     out  DATA_W  sample out, index order 0..FRAME_LEN-1
//  overrun      out  1       sticky: sample dropped; cleared by reset/flush
//  drop_cnt     out  16      dropped samples, saturates at 16'hFFFF; cleared by reset/flush
//  peak_level   out  DATA_W-1  max |sample| of last completed frame (see CONFIGURATION)
//  peak_valid   out  1       one-cycle pulse when peak_level updates
// BEHAVIOUR
//  Reset: all outputs 0; wr_bank=0, rd_bank=0, wr_ptr=0, bank_full=2'b00, FSM IDLE.
//  Processing (comb): mix uses DATA_W+1 sum then >>>1. Shift result clamps to 2^(DATA_W-1)-1 / -2^(DATA_W-1) on overflow.
//  Write: on in_valid, if !bank_full[wr_bank] write mem[wr_bank][wr_ptr], wr_ptr++. At wr_ptr==FRAME_LEN-1:
//   bank_full[wr_bank]<=1, wr_bank toggles, wr_ptr<=0. If bank_full[wr_bank]: drop, overrun<=1, drop_cnt++ (sat).
//  Read FSM: IDLE -> FETCH when bank_full[rd_bank]; FETCH presents addr rd_ptr to sync RAM (1-cycle read);
//   STREAM: src_valid=1, src_data=RAM q; src_sop=(rd_ptr==0), src_eop=(rd_ptr==FRAME_LEN-1).
//   STREAM & src_ready: if eop -> bank_full[rd_bank]<=0, rd_bank toggles, rd_ptr<=0, IDLE; else rd_ptr++, FETCH.
//   STREAM & !src_ready: hold all outputs stable. Throughput 1 sample / 2 cycles.
//  Latency: src_valid+sop first high 3 cycles after the in_valid cycle carrying a frame's last sample (read idle).
//  Simultaneous write-complete and read-eop same cycle touch different bank_full bits; both take effect.
//  Write never targets a full bank, so read data is never overwritten mid-stream.
//  flush/reset mid-frame: partial frames discarded, src_valid low next cycle, no eop emitted; reset wins over flush.
//  in_valid during flush cycle is ignored (not counted as drop).
// CONFIGURATION
//  PEAK_METER_EN defined: track max |processed sample| (most-negative clamps to 2^(DATA_W-1)-1) over accepted
//   samples of current write frame; on frame completion latch to peak_level, pulse peak_valid, restart at 0.
//   Dropped samples excluded. Tracker zeroed by reset/flush.
//  PEAK_METER_EN undefined: peak_level and peak_valid tied 0; no tracker logic.
// TESTING (FRAME_LEN=8, DATA_W=32, src_ready=1 unless stated)
//  1 reset -> all outputs 0; 8 in_valid pulses L=1..8, ch_sel=0, gain 0 -> sop with data 1, eop with data 8, 3-cycle latency.
//  2 ch_sel=2, L=100 R=-50 -> 25; ch_sel=1 -> -50; gain 3, L=32'h1000_0000 -> 32'h7FFF_FFFF; L=32'h9000_0000 -> 32'h8000_0000.
//  3 src_ready=0 throughout, 24 samples in -> banks 0,1 full, last 8 dropped: overrun=1, drop_cnt=8; ready=1 -> frames 0,1 out in order.
//  4 src_ready toggled every cycle mid-frame -> src_data/sop/eop stable while valid&!ready; no sample lost/duplicated.
//  5 flush at sample 5 of frame, and while streaming index 3 -> src_valid 0 next cycle, drop_cnt=0, next 8 samples form clean frame.
//  6 PEAK_METER_EN: frame {3,-7,2,0,1,-1,5,4} -> peak_level=7, peak_valid one pulse at frame completion; undefined -> stays 0.

Source files
------------

// File: rtl/audio_frame_streamer.sv
// ----------------------------------------------------------------------------
// audio_frame_streamer
//
// Ping-pong framer between the audio codec sample stream and an FFT sink.
// Each stereo sample is channel-selected or mixed, shifted left by a
// saturating gain, and written into one of two frame banks. When a bank
// holds FRAME_LEN samples it is streamed out over a valid/ready interface
// with sop/eop framing. The audio input is never back-pressured: samples
// that arrive while the target bank is still full are dropped and counted.
//
// Parameters
//   DATA_W      sample width, two's complement
//   FRAME_LEN   samples per frame (power of two, >= 4)
//
// Ports
//   CLOCK_50    system clock, all logic on posedge
//   reset       synchronous active-high reset (wins over flush)
//   flush       synchronous abort: empties both banks, zeroes pointers
//   ch_sel      0=left 1=right 2=(L+R)>>>1 3=left
//   gain_shift  left shift 0..7, saturating
//   in_valid    one-cycle pulse per stereo sample
//   in_left     left sample
//   in_right    right sample
//   src_ready   downstream ready
//   src_valid   src_data valid
//   src_sop     first sample of frame
//   src_eop     last sample of frame
//   src_data    output sample, index order 0..FRAME_LEN-1
//   overrun     sticky flag, a sample was dropped
//   drop_cnt    dropped sample count, saturating
//   peak_level  max |sample| of the last completed frame
//   peak_valid  one-cycle pulse when peak_level updates
//
// Build option
//   PEAK_METER_EN  when defined, enables the per-frame peak tracker;
//                  otherwise peak_level / peak_valid are tied to 0.
// ----------------------------------------------------------------------------
// Read FSM states
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for bank_full[rd_bank]
//   S_FETCH  | RAM address = {rd_bank, rd_ptr}, data registered at edge
//   S_STREAM | src_valid high, holding until src_ready
// ----------------------------------------------------------------------------
module audio_frame_streamer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 8192
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              flush,
    input  logic [1:0]        ch_sel,
    input  logic [2:0]        gain_shift,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              src_ready,
    output logic              src_valid,
    output logic              src_sop,
    output logic              src_eop,
    output logic [DATA_W-1:0] src_data,
    output logic              overrun,
    output logic [15:0]       drop_cnt,
    output logic [DATA_W-2:0] peak_level,
    output logic              peak_valid
);

    localparam int ADDR_W = $clog2(FRAME_LEN);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM
    } state_t;

    state_t            state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] mem [2*FRAME_LEN];

    logic [DATA_W:0]   mix_sum;
    logic [DATA_W-1:0] mix_val;
    logic [DATA_W+7:0] shift_wide;
    logic [8:0]        shift_top;
    logic [DATA_W-1:0] proc_val;

    logic wr_accept;
    logic wr_last;
    logic rd_last;
    logic rd_done;
    logic mem_re;

    // Sample processing: mix in DATA_W+1 bits, then shift in 8 extra bits so
    // overflow is visible as a disagreement among the top 9 bits.
    always_comb begin
        mix_sum = {in_left[DATA_W-1], in_left} + {in_right[DATA_W-1], in_right};
        case (ch_sel)
            2'd1:    mix_val = in_right;
            2'd2:    mix_val = DATA_W'(mix_sum >> 1);
            default: mix_val = in_left;
        endcase
        shift_wide = {{8{mix_val[DATA_W-1]}}, mix_val} << gain_shift;
        shift_top  = shift_wide[DATA_W+7:DATA_W-1];
        if ((&shift_top) || !(|shift_top)) begin
            proc_val = shift_wide[DATA_W-1:0];
        end else if (shift_wide[DATA_W+7]) begin
            proc_val = SAT_MIN;
        end else begin
            proc_val = SAT_MAX;
        end
    end

    assign wr_last   = (wr_ptr_q == PTR_LAST);
    assign rd_last   = (rd_ptr_q == PTR_LAST);
    assign wr_accept = in_valid && !flush && !bank_full_q[wr_bank_q];
    assign rd_done   = (state_q == S_STREAM) && src_ready && rd_last;

    // Write side and bank bookkeeping. A completing write and a completing
    // read always refer to different banks, so both bank_full updates apply.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_ptr_d    = wr_ptr_q;
        bank_full_d = bank_full_q;
        overrun_d   = overrun_q;
        drop_cnt_d  = drop_cnt_q;

        if (rd_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end

        if (wr_accept) begin
            if (wr_last) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                wr_ptr_d               = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
        end else if (in_valid && !flush) begin
            overrun_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end

        if (flush) begin
            wr_bank_d   = 1'b0;
            wr_ptr_d    = '0;
            bank_full_d = 2'b00;
            overrun_d   = 1'b0;
            drop_cnt_d  = '0;
        end
    end

    // Read FSM
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_ptr_d  = rd_ptr_q;
        mem_re    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_re  = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (src_ready) begin
                    if (rd_last) begin
                        rd_bank_d = ~rd_bank_q;
                        rd_ptr_d  = '0;
                        state_d   = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        state_d  = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d   = S_IDLE;
            rd_bank_d = 1'b0;
            rd_ptr_d  = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bank_full_q <= 2'b00;
            overrun_q   <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_full_q <= bank_full_d;
            overrun_q   <= overrun_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Frame storage: plain RAM array, kept free of reset so it maps to block RAM.
    always_ff @(posedge CLOCK_50) begin
        if (wr_accept) begin
            mem[{wr_bank_q, wr_ptr_q}] <= proc_val;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (mem_re) begin
            rd_data_q <= mem[{rd_bank_q, rd_ptr_q}];
        end
    end

    assign src_valid = (state_q == S_STREAM);
    assign src_sop   = src_valid && (rd_ptr_q == '0);
    assign src_eop   = src_valid && rd_last;
    assign src_data  = rd_data_q;
    assign overrun   = overrun_q;
    assign drop_cnt  = drop_cnt_q;

`ifdef PEAK_METER_EN
    logic [DATA_W-2:0] peak_run_q, peak_run_d;
    logic [DATA_W-2:0] peak_level_q, peak_level_d;
    logic              peak_valid_q, peak_valid_d;
    logic [DATA_W-2:0] samp_abs;
    logic [DATA_W-2:0] peak_cand;

    // |x| fits in DATA_W-1 bits except for the most negative value, which
    // clamps to the largest positive magnitude.
    always_comb begin
        if (!proc_val[DATA_W-1]) begin
            samp_abs = proc_val[DATA_W-2:0];
        end else if (proc_val == SAT_MIN) begin
            samp_abs = '1;
        end else begin
            samp_abs = ~proc_val[DATA_W-2:0] + (DATA_W-1)'(1);
        end
        peak_cand = (samp_abs > peak_run_q) ? samp_abs : peak_run_q;

        peak_run_d   = peak_run_q;
        peak_level_d = peak_level_q;
        peak_valid_d = 1'b0;
        if (wr_accept) begin
            if (wr_last) begin
                peak_level_d = peak_cand;
                peak_valid_d = 1'b1;
                peak_run_d   = '0;
            end else begin
                peak_run_d = peak_cand;
            end
        end
        if (flush) begin
            peak_run_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            peak_run_q   <= '0;
            peak_level_q <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            peak_run_q   <= peak_run_d;
            peak_level_q <= peak_level_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_level = peak_level_q;
    assign peak_valid = peak_valid_q;
`else
    assign peak_level = '0;
    assign peak_valid = 1'b0;
`endif

endmodule
